// File: rtl/inst_fetch_ctrl_if.sv
// Fetch bus bundle: ROM read port plus IF/ID valid/ready output stage.
// master = fetch controller, slave = ROM/decode side.
interface inst_fetch_ctrl_if #(
   parameter int ADDR_W = 6
);
   logic              rom_ce;
   logic [ADDR_W-1:0] rom_addr;
   logic [31:0]       rom_inst;
   logic              id_ready;
   logic              id_valid;
   logic [31:0]       id_pc;
   logic [31:0]       id_inst;

   modport master (
      output rom_ce,
      output rom_addr,
      input  rom_inst,
      input  id_ready,
      output id_valid,
      output id_pc,
      output id_inst
   );

   modport slave (
      input  rom_ce,
      input  rom_addr,
      output rom_inst,
      output id_ready,
      input  id_valid,
      input  id_pc,
      input  id_inst
   );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Fetch controller: owns the PC, reads the instruction ROM and feeds
// the decode stage through a valid/ready IF/ID register.
// Ports: clk, rst_n (async low); bus (master: rom_ce/rom_addr/rom_inst,
// id_valid/id_pc/id_inst/id_ready); br_valid_i/br_target_i redirect;
// halt_i level stall; fetch_cnt_o delivered count when FETCH_CNT_EN.
module inst_fetch_ctrl #(
   parameter int          ADDR_W   = 6,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic              clk,
   input  logic              rst_n,
   inst_fetch_ctrl_if.master bus,
   input  logic              br_valid_i,
   input  logic [31:0]       br_target_i,
   input  logic              halt_i
`ifdef FETCH_CNT_EN
   ,
   output logic [31:0]       fetch_cnt_o
`endif
);

   localparam logic [31:0] PC_RST = RESET_PC & ~32'd3;

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_FETCH,
      ST_HALTED
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        vld_q, vld_d;
   logic [31:0] idpc_q, idpc_d;
   logic [31:0] inst_q, inst_d;

   logic fetching;
   logic slot_free;
   logic capture;
   logic consumed;

   assign fetching  = (state_q == ST_FETCH);
   assign slot_free = !vld_q || bus.id_ready;
   assign capture   = fetching && slot_free
                      && !br_valid_i && !halt_i;
   assign consumed  = vld_q && bus.id_ready;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_WAIT:   state_d = ST_FETCH;
         ST_FETCH:  if (halt_i) state_d = ST_HALTED;
         ST_HALTED: if (!halt_i) state_d = ST_FETCH;
         default:   state_d = ST_WAIT;
      endcase
   end

   // Redirect wins over capture and flushes even a stalled output.
   always_comb begin
      pc_d   = pc_q;
      vld_d  = vld_q;
      idpc_d = idpc_q;
      inst_d = inst_q;
      if (br_valid_i) begin
         pc_d  = br_target_i & ~32'd3;
         vld_d = 1'b0;
      end else if (capture) begin
         idpc_d = pc_q;
         inst_d = bus.rom_inst;
         vld_d  = 1'b1;
         pc_d   = pc_q + 32'd4;
      end else if (consumed) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_WAIT;
         pc_q    <= PC_RST;
         vld_q   <= 1'b0;
         idpc_q  <= 32'd0;
         inst_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         vld_q   <= vld_d;
         idpc_q  <= idpc_d;
         inst_q  <= inst_d;
      end
   end

   assign bus.rom_ce   = fetching;
   assign bus.rom_addr = pc_q[ADDR_W+1:2];
   assign bus.id_valid = vld_q;
   assign bus.id_pc    = idpc_q;
   assign bus.id_inst  = inst_q;

`ifdef FETCH_CNT_EN
   logic [31:0] cnt_q, cnt_d;

   // Counts every handshake, including one flushed in the same cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (consumed) cnt_d = cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= 32'd0;
      else        cnt_q <= cnt_d;
   end

   assign fetch_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Randomized bench for inst_fetch_ctrl against a transaction-level
// model of the fetch pipeline.
module tb_inst_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        br = 1'b0;
   logic [31:0] tgt = 32'd0;
   logic        hlt = 1'b0;
   logic        rdy = 1'b0;
   logic [31:0] rom [64];
   logic [31:0] cnt_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   inst_fetch_ctrl_if #(.ADDR_W(6)) bus ();

   assign bus.rom_inst = rom[bus.rom_addr];
   assign bus.id_ready = rdy;

   inst_fetch_ctrl #(
      .ADDR_W  (6),
      .RESET_PC(32'h0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .br_valid_i (br),
      .br_target_i(tgt),
      .halt_i     (hlt)
`ifdef FETCH_CNT_EN
      ,
      .fetch_cnt_o(cnt_o)
`endif
   );

`ifndef FETCH_CNT_EN
   assign cnt_o = 32'd0;
`endif

   // Model: started = past the post-reset wait cycle; halted = last
   // sampled halt once started; out_* = what decode should see.
   bit          m_started;
   bit          m_halted;
   logic [31:0] m_pc;
   bit          m_ov;
   logic [31:0] m_opc;
   logic [31:0] m_oinst;
   logic [31:0] m_cnt;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void m_reset();
      m_started = 0;
      m_halted  = 0;
      m_pc      = 32'h0;
      m_ov      = 0;
      m_opc     = 32'h0;
      m_oinst   = 32'h0;
      m_cnt     = 32'h0;
   endfunction

   task automatic check_outs(input string pfx);
      chk({pfx, "_ce"}, {31'd0, bus.rom_ce},
          {31'd0, m_started && !m_halted});
      chk({pfx, "_addr"}, {26'd0, bus.rom_addr}, {26'd0, m_pc[7:2]});
      chk({pfx, "_vld"}, {31'd0, bus.id_valid}, {31'd0, m_ov});
      chk({pfx, "_pc"}, bus.id_pc, m_opc);
      chk({pfx, "_inst"}, bus.id_inst, m_oinst);
`ifdef FETCH_CNT_EN
      chk({pfx, "_cnt"}, cnt_o, m_cnt);
`endif
   endtask

   // One clock: inputs already applied, check, advance model, clock.
   task automatic cycle(input string pfx,
                        input logic b, input logic [31:0] t,
                        input logic h, input logic r);
      bit fire;
      bit can_fetch;
      br  = b;
      tgt = t;
      hlt = h;
      rdy = r;
      #1;
      check_outs(pfx);
      fire      = m_ov && r;
      can_fetch = m_started && !m_halted;
      if (fire) m_cnt = m_cnt + 1;
      if (b) begin
         m_pc = t & ~32'd3;
         m_ov = 0;
      end else if (can_fetch && !h && (!m_ov || r)) begin
         m_opc   = m_pc;
         m_oinst = rom[m_pc[7:2]];
         m_ov    = 1;
         m_pc    = m_pc + 4;
      end else if (fire) begin
         m_ov = 0;
      end
      m_halted  = m_started ? h : 1'b0;
      m_started = 1;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = $urandom;
      m_reset();
      #12;
      check_outs("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // T1: startup and streaming
      for (int i = 0; i < 4; i++) cycle("t1", 0, 0, 0, 1);
      // T2: backpressure on id_pc=8
      for (int i = 0; i < 3; i++) cycle("t2", 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) cycle("t2r", 0, 0, 0, 1);
      // T3: branch while stalled
      cycle("t3s", 0, 0, 0, 0);
      cycle("t3b", 1, 32'h43, 0, 0);
      for (int i = 0; i < 2; i++) cycle("t3", 0, 0, 0, 1);
      // T4: wrap of rom address
      cycle("t4b", 1, 32'hFC, 0, 1);
      for (int i = 0; i < 3; i++) cycle("t4", 0, 0, 0, 1);
      // T5: halt, drain, retarget while halted, resume
      cycle("t5s", 0, 0, 0, 0);
      cycle("t5h", 0, 0, 1, 0);
      cycle("t5h", 0, 0, 1, 1);
      cycle("t5b", 1, 32'h20, 1, 0);
      cycle("t5h", 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) cycle("t5", 0, 0, 0, 1);
      cycle("t5bh", 1, 32'h80, 1, 1);
      for (int i = 0; i < 3; i++) cycle("t5r", 0, 0, 0, 1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cycle("rnd",
               $urandom_range(0, 9) == 0,
               $urandom,
               $urandom_range(0, 7) == 0,
               $urandom_range(0, 9) < 7);
      end

      // Async reset mid-stream, released before the next edge
      rst_n = 1'b0;
      #1;
      m_reset();
      check_outs("arst");
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         cycle("post",
               $urandom_range(0, 11) == 0,
               $urandom,
               $urandom_range(0, 9) == 0,
               $urandom_range(0, 9) < 6);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
